// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register slave: FSM state encoding and the
// width of the access-phase wait-state counter.
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    // Wait-state counter width; WAIT_CYC must fit (0..15).
    localparam int WCNT_W = 4;

endpackage

// File: rtl/apb_irq_status.sv
// ---------------------------------------------------------------------------
// apb_irq_status
// Write-1-to-clear status register with set priority, plus a registered irq.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   event_in    - one-cycle event pulses; a 1 sets the matching status bit
//   clr_en      - APB write to the status register commits this cycle
//   clr_mask    - write data; a 1 clears the matching status bit
//   status      - current status register value
//   irq         - OR of status bits, registered (one cycle behind status)
// ---------------------------------------------------------------------------
module apb_irq_status #(
    parameter int DATA_BW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_BW-1:0] event_in,
    input  logic               clr_en,
    input  logic [DATA_BW-1:0] clr_mask,
    output logic [DATA_BW-1:0] status,
    output logic               irq
);

    logic [DATA_BW-1:0] clr_bits;

    assign clr_bits = clr_en ? clr_mask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            // Clear first, then OR in events: a simultaneous set wins.
            status <= (status & ~clr_bits) | event_in;
            irq    <= |status;
        end
    end

endmodule

// File: rtl/apb_slv_regs.sv
// ---------------------------------------------------------------------------
// apb_slv_regs
// APB slave with NUM_REGS-1 plain R/W registers and one W1C status register
// at the top index. Configurable access-phase wait states.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   psel, penable, pwrite   - APB controls
//   paddr, pwdata           - APB address / write data
//   prdata, pready, pslverr - APB response (prdata is 0 outside read pready)
//   ctrl_regs               - flat image of R/W regs, reg i at [i*DATA_BW +: DATA_BW]
//   event_in                - event pulses setting status bits
//   irq                     - registered OR of status bits
// ---------------------------------------------------------------------------
module apb_slv_regs
    import apb_pkg::*;
#(
    parameter int DATA_BW  = 8,
    parameter int ADDR_BW  = 8,
    parameter int NUM_REGS = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            psel,
    input  logic                            penable,
    input  logic                            pwrite,
    input  logic [ADDR_BW-1:0]              paddr,
    input  logic [DATA_BW-1:0]              pwdata,
    output logic [DATA_BW-1:0]              prdata,
    output logic                            pready,
    output logic                            pslverr,
    output logic [(NUM_REGS-1)*DATA_BW-1:0] ctrl_regs,
    input  logic [DATA_BW-1:0]              event_in,
    output logic                            irq
);

    localparam int NRW = NUM_REGS - 1;

    apb_state_e         state, state_nxt;
    logic [ADDR_BW-1:0] addr_q;
    logic               write_q;
    logic [WCNT_W-1:0]  wait_cnt;
    logic [DATA_BW-1:0] regs [NRW];
    logic [DATA_BW-1:0] status;
    logic [DATA_BW-1:0] rd_sel;
    logic               addr_ok, is_status, done, wr_commit, setup_hit;

    // Widened compare so NUM_REGS == 2**ADDR_BW does not wrap to zero.
    assign addr_ok   = {1'b0, addr_q} < (ADDR_BW+1)'(NUM_REGS);
    assign is_status = addr_q == ADDR_BW'(NRW);
    assign setup_hit = (state == ST_IDLE) && psel && !penable;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (psel && !penable) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = psel ? ST_ACCESS : ST_IDLE;
            // Master dropping psel/penable aborts; otherwise leave once done.
            ST_ACCESS: if (!psel || !penable || wait_cnt == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        done      = (state == ST_ACCESS) && psel && penable && (wait_cnt == '0);
        pready    = done;
        pslverr   = done && !addr_ok;
        wr_commit = done && write_q && addr_ok;
        prdata    = (done && !write_q && addr_ok) ? rd_sel : '0;
    end

    // Transfer context latched at the setup edge; counter runs only in a
    // live access phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wait_cnt <= '0;
        end else if (setup_hit) begin
            addr_q   <= paddr;
            write_q  <= pwrite;
            wait_cnt <= WCNT_W'(WAIT_CYC);
        end else if (state == ST_ACCESS && psel && penable && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WCNT_W'(1);
        end
    end

    // Read mux: status by default, overridden by a matching R/W register.
    always_comb begin
        rd_sel = status;
        for (int i = 0; i < NRW; i++)
            if (addr_q == ADDR_BW'(i)) rd_sel = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NRW; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NRW; i++)
                if (addr_q == ADDR_BW'(i)) regs[i] <= pwdata;
        end
    end

    for (genvar g = 0; g < NRW; g++) begin : g_flat
        assign ctrl_regs[g*DATA_BW +: DATA_BW] = regs[g];
    end

    apb_irq_status #(.DATA_BW(DATA_BW)) u_status (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_in),
        .clr_en   (wr_commit && is_status),
        .clr_mask (pwdata),
        .status   (status),
        .irq      (irq)
    );

endmodule

// File: tb/tb_apb_slv_regs.sv
// ---------------------------------------------------------------------------
// tb_apb_slv_regs
// Directed bench: instance A uses WAIT_CYC=2, instance B uses WAIT_CYC=0.
// Inputs are driven on the falling edge; outputs sampled 1ns later.
// Latency is counted in penable=1 cycles up to and including pready:
// WAIT_CYC+2 (one SETUP-state cycle plus WAIT_CYC+1 ACCESS-state cycles).
// ---------------------------------------------------------------------------
module tb_apb_slv_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        psel_a, pen_a, pw_a, rdy_a, err_a, irq_a;
    logic [7:0]  addr_a, wd_a, ev_a, rd_a;
    logic [55:0] ctrl_a;
    logic        psel_b, pen_b, pw_b, rdy_b, err_b, irq_b;
    logic [7:0]  addr_b, wd_b, ev_b, rd_b;
    logic [55:0] ctrl_b;

    apb_slv_regs #(.DATA_BW(8), .ADDR_BW(8), .NUM_REGS(8), .WAIT_CYC(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .psel(psel_a), .penable(pen_a), .pwrite(pw_a),
        .paddr(addr_a), .pwdata(wd_a), .prdata(rd_a), .pready(rdy_a),
        .pslverr(err_a), .ctrl_regs(ctrl_a), .event_in(ev_a), .irq(irq_a)
    );

    apb_slv_regs #(.DATA_BW(8), .ADDR_BW(8), .NUM_REGS(8), .WAIT_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .psel(psel_b), .penable(pen_b), .pwrite(pw_b),
        .paddr(addr_b), .pwdata(wd_b), .prdata(rd_b), .pready(rdy_b),
        .pslverr(err_b), .ctrl_regs(ctrl_b), .event_in(ev_b), .irq(irq_b)
    );

    bit         use_b;
    logic [7:0] rd_o;
    logic       rdy_o, err_o;
    assign rd_o  = use_b ? rd_b  : rd_a;
    assign rdy_o = use_b ? rdy_b : rdy_a;
    assign err_o = use_b ? err_b : err_a;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic s, input logic e, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (b) begin psel_b = s; pen_b = e; pw_b = w; addr_b = a; wd_b = d; end
        else   begin psel_a = s; pen_a = e; pw_a = w; addr_a = a; wd_a = d; end
    endtask

    task automatic set_ev(input bit b, input logic [7:0] v);
        if (b) ev_b = v; else ev_a = v;
    endtask

    task automatic idle(input bit b);
        @(negedge clk);
        drive(b, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_ev(b, 8'h00);
        #1;
    endtask

    // Full transfer; returns sitting in the pready cycle. evt is driven on
    // event_in during the commit cycle.
    task automatic xfer(input string tag, input bit b, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_err,
                        input int exp_lat, input logic [7:0] evt);
        int  n;
        bit  got;
        use_b = b;
        n     = 0;
        got   = 0;
        @(negedge clk);
        drive(b, 1'b1, 1'b0, wr, a, d);
        #1;
        chk({tag, " setup pready"}, 64'(rdy_o), 64'd0);
        while (!got && n < 16) begin
            @(negedge clk);
            drive(b, 1'b1, 1'b1, wr, a, d);
            #1;
            n++;
            if (rdy_o) got = 1;
            else begin
                chk({tag, " wait prdata"}, 64'(rd_o), 64'd0);
                chk({tag, " wait pslverr"}, 64'(err_o), 64'd0);
            end
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " prdata"}, 64'(rd_o), 64'(exp_rd));
        chk({tag, " pslverr"}, 64'(err_o), 64'(exp_err));
        set_ev(b, evt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        use_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_ev(1'b0, 8'h00);
        set_ev(1'b1, 8'h00);

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        chk("rst prdata",  64'(rd_a),  64'd0);
        chk("rst pready",  64'(rdy_a), 64'd0);
        chk("rst pslverr", 64'(err_a), 64'd0);
        chk("rst irq",     64'(irq_a), 64'd0);
        chk("rst ctrl_a",  64'(ctrl_a), 64'd0);
        chk("rst ctrl_b",  64'(ctrl_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- basic write / read, WAIT_CYC=2 -> latency 4 ----
        xfer("wr3", 1'b0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);
        chk("wr3 ctrl", 64'(ctrl_a), 64'h0000_0000_A500_0000);
        xfer("rd3", 1'b0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 4, 8'h00);
        idle(1'b0);
        chk("rd3 prdata after", 64'(rd_a), 64'd0);

        // last R/W register
        xfer("wr6", 1'b0, 1'b1, 8'h06, 8'h5C, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);
        chk("wr6 ctrl", 64'(ctrl_a), 64'h005C_0000_A500_0000);
        xfer("rd6", 1'b0, 1'b0, 8'h06, 8'h00, 8'h5C, 1'b0, 4, 8'h00);
        idle(1'b0);

        // ---- status: event pulse, registered irq ----
        @(negedge clk); set_ev(1'b0, 8'h81);
        @(negedge clk); set_ev(1'b0, 8'h00); #1;
        chk("irq lag", 64'(irq_a), 64'd0);
        @(negedge clk); #1;
        chk("irq set", 64'(irq_a), 64'd1);
        xfer("rd7 81", 1'b0, 1'b0, 8'h07, 8'h00, 8'h81, 1'b0, 4, 8'h00);
        idle(1'b0);
        xfer("w1c 01", 1'b0, 1'b1, 8'h07, 8'h01, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);
        xfer("rd7 80", 1'b0, 1'b0, 8'h07, 8'h00, 8'h80, 1'b0, 4, 8'h00);
        idle(1'b0);
        chk("irq hold", 64'(irq_a), 64'd1);
        xfer("w1c 80", 1'b0, 1'b1, 8'h07, 8'h80, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);
        chk("irq fall lag", 64'(irq_a), 64'd1);
        idle(1'b0);
        chk("irq fall", 64'(irq_a), 64'd0);
        xfer("rd7 00", 1'b0, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);

        // set wins over simultaneous clear
        xfer("w1c race", 1'b0, 1'b1, 8'h07, 8'h01, 8'h00, 1'b0, 4, 8'h01);
        idle(1'b0);
        xfer("rd7 race", 1'b0, 1'b0, 8'h07, 8'h00, 8'h01, 1'b0, 4, 8'h00);
        idle(1'b0);
        xfer("w1c clr", 1'b0, 1'b1, 8'h07, 8'h01, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);
        xfer("rd7 clr", 1'b0, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);

        // ---- out-of-range address ----
        xfer("rd20", 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 4, 8'h00);
        idle(1'b0);
        xfer("wr20", 1'b0, 1'b1, 8'h20, 8'hFF, 8'h00, 1'b1, 4, 8'h00);
        idle(1'b0);
        chk("wr20 ctrl", 64'(ctrl_a), 64'h005C_0000_A500_0000);
        chk("wr20 irq", 64'(irq_a), 64'd0);

        // ---- WAIT_CYC=0: back-to-back writes, latency 2 ----
        xfer("b2b w0", 1'b1, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 2, 8'h00);
        xfer("b2b w1", 1'b1, 1'b1, 8'h01, 8'h22, 8'h00, 1'b0, 2, 8'h00);
        idle(1'b1);
        chk("b2b ctrl", 64'(ctrl_b), 64'h0000_0000_0000_2211);

        // abort: psel dropped in ACCESS, then penable without a setup phase
        use_b = 1'b1;
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 8'h33);
        @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 8'h33); #1;
        chk("abort setup pready", 64'(rdy_b), 64'd0);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h33); #1;
        chk("abort pready", 64'(rdy_b), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 8'h33); #1;
            chk("abort idle pready", 64'(rdy_b), 64'd0);
        end
        idle(1'b1);
        chk("abort ctrl", 64'(ctrl_b), 64'h0000_0000_0000_2211);
        xfer("after abort", 1'b1, 1'b1, 8'h02, 8'h33, 8'h00, 1'b0, 2, 8'h00);
        idle(1'b1);
        chk("after abort ctrl", 64'(ctrl_b), 64'h0000_0000_0033_2211);

        // ---- async reset mid-transfer ----
        use_b = 1'b0;
        @(negedge clk); set_ev(1'b0, 8'h40);
        @(negedge clk); set_ev(1'b0, 8'h00);
        @(negedge clk); #1;
        chk("pre-rst irq", 64'(irq_a), 64'd1);
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h77);
        @(negedge clk); drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'h77);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst pready", 64'(rdy_a), 64'd0);
        chk("mid-rst prdata", 64'(rd_a), 64'd0);
        chk("mid-rst irq", 64'(irq_a), 64'd0);
        chk("mid-rst ctrl", 64'(ctrl_a), 64'd0);
        idle(1'b0);
        rst_n = 1'b1;
        idle(1'b0);
        xfer("rd5 post-rst", 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 4, 8'h00);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
